// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control with trap sequencer and stall watchdog
//
// Purpose: drives per-register hold (stall_o) and bubble-load (flush_o) for an
// NUM_STAGES-deep pipeline from per-stage stall/flush requests, runs the
// drain -> flush -> redirect sequence on trap entry, and counts consecutive
// fetch stalls.
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stallreq_i   in   [NUM_STAGES] stage j cannot advance
//   flushreq_i   in   [NUM_STAGES] stage j requests flush of registers 1..j
//   enter_i      in   trap/interrupt entry request (level, sampled in IDLE)
//   stall_o      out  [NUM_STAGES] hold pipeline register k
//   flush_o      out  [NUM_STAGES] load a bubble into register k (bit 0 always 0)
//   redirect_o   out  pc_reg loads the trap vector (one cycle)
//   busy_o       out  trap sequence in progress
//   stall_cnt_o  out  [WDOG_WIDTH] consecutive cycles with stall_o[0]=1, saturating
//   wdog_o       out  registered: stall_cnt_o is all-ones
module pipe_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDOG_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic [NUM_STAGES-1:0] flushreq_i,
    input  logic                  enter_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  redirect_o,
    output logic                  busy_o,
    output logic [WDOG_WIDTH-1:0] stall_cnt_o,
    output logic                  wdog_o
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [WDOG_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                  wdog_q, wdog_d;

    logic [NUM_STAGES-1:0] base_stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] flush_range;

    // Walk from the last stage towards pc_reg. acc_s holds the OR of the
    // stall requests strictly above the current stage when a flush request
    // is examined, so a request is honoured only if nothing downstream
    // stalls. acc_f is sticky: an honoured request at j flushes every
    // register 1..j, which also gives the union of several requests.
    always_comb begin
        logic acc_s;
        logic acc_f;
        acc_s       = 1'b0;
        acc_f       = 1'b0;
        base_stall  = '0;
        flush_range = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (flushreq_i[k] && !acc_s) begin
                acc_f = 1'b1;
            end
            acc_s = acc_s | stallreq_i[k];
            base_stall[k] = acc_s;
            if (k >= 1) begin
                flush_range[k] = acc_f;
            end
        end
    end

    // A bubble goes in where a held register feeds one that keeps moving.
    always_comb begin
        bubble = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            bubble[k] = base_stall[k-1] & ~base_stall[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        // Flush wins over stall on the same register; bit 0 is never in the
        // flush range so pc_reg keeps its stall while the redirect arrives.
        stall_o     = base_stall & ~flush_range;
        flush_o     = bubble | flush_range;
        redirect_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enter_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                // Fetch frozen, decode fed bubbles, branch flushes ignored
                // while older instructions retire.
                stall_o    = base_stall;
                flush_o    = bubble;
                stall_o[0] = 1'b1;
                flush_o[1] = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_FLUSH;
                end else if (stallreq_i == '0) begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                    // Leave as soon as the last stall-free drain cycle retires.
                    if (drain_cnt_q == DW'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                stall_o    = '0;
                flush_o    = {{(NUM_STAGES-1){1'b1}}, 1'b0};
                redirect_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Watchdog tracks the final fetch hold, including the one forced by DRAIN.
    always_comb begin
        stall_cnt_d = '0;
        if (stall_o[0]) begin
            stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + WDOG_WIDTH'(1);
        end
        wdog_d = (stall_cnt_q == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign stall_cnt_o = stall_cnt_q;
    assign wdog_o      = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] stallreq;
    logic [4:0] flushreq;
    logic       enter;

    logic [4:0] stall_o, flush_o;
    logic       redirect_o, busy_o, wdog_o;
    logic [2:0] stall_cnt_o;

    logic [4:0] z_stall_o, z_flush_o;
    logic       z_redirect_o, z_busy_o, z_wdog_o;
    logic [2:0] z_stall_cnt_o;

    pipe_ctrl #(.NUM_STAGES(5), .DRAIN_CYCLES(2), .WDOG_WIDTH(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq), .flushreq_i(flushreq),
        .enter_i(enter), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_o(redirect_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o),
        .wdog_o(wdog_o)
    );

    pipe_ctrl #(.NUM_STAGES(5), .DRAIN_CYCLES(0), .WDOG_WIDTH(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .stallreq_i(stallreq), .flushreq_i(flushreq),
        .enter_i(enter), .stall_o(z_stall_o), .flush_o(z_flush_o),
        .redirect_o(z_redirect_o), .busy_o(z_busy_o), .stall_cnt_o(z_stall_cnt_o),
        .wdog_o(z_wdog_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_STALL = 0, S_FLUSH = 1, S_REDIR = 2, S_BUSY = 3,
                   S_CNT = 4, S_WDOG = 5, S_Z_REDIR = 6, S_Z_BUSY = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STALL:   return 32'(stall_o);
            S_FLUSH:   return 32'(flush_o);
            S_REDIR:   return 32'(redirect_o);
            S_BUSY:    return 32'(busy_o);
            S_CNT:     return 32'(stall_cnt_o);
            S_WDOG:    return 32'(wdog_o);
            S_Z_REDIR: return 32'(z_redirect_o);
            S_Z_BUSY:  return 32'(z_busy_o);
            default:   return 32'hdead_beef;
        endcase
    endfunction

    task automatic chk(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic settle();
        exp_t x;
        logic [31:0] got;
        #1;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            got = obs(x.sel);
            checks++;
            assert (got === x.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, got, x.exp);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stallreq = '0; flushreq = '0; enter = 1'b0;
        #2;
        chk("rst_busy", S_BUSY, 0); chk("rst_redir", S_REDIR, 0);
        chk("rst_cnt", S_CNT, 0);   chk("rst_wdog", S_WDOG, 0);
        chk("rst_stall", S_STALL, 0); chk("rst_flush", S_FLUSH, 0);
        settle();
        #10 rst_n = 1'b1;
        next_cycle();

        // base stall and bubble
        stallreq = 5'b00100;
        chk("base_stall", S_STALL, 5'b00111); chk("base_bubble", S_FLUSH, 5'b01000);
        settle();
        next_cycle();
        stallreq = '0;
        chk("idle_stall", S_STALL, 0); chk("idle_flush", S_FLUSH, 0);
        chk("cnt_one", S_CNT, 1);
        settle();
        next_cycle();
        chk("cnt_clear", S_CNT, 0);

        // flush requests
        flushreq = 5'b00100;
        chk("fl_flush", S_FLUSH, 5'b00110); chk("fl_stall", S_STALL, 0);
        settle();
        stallreq = 5'b01000;
        chk("fl_mask_flush", S_FLUSH, 5'b10000); chk("fl_mask_stall", S_STALL, 5'b01111);
        settle();
        flushreq = 5'b10010; stallreq = '0;
        chk("fl_multi_flush", S_FLUSH, 5'b11110); chk("fl_multi_stall", S_STALL, 0);
        settle();
        stallreq = 5'b01000;
        chk("fl_win_flush", S_FLUSH, 5'b11110); chk("fl_win_stall", S_STALL, 5'b00001);
        settle();
        next_cycle();
        stallreq = '0; flushreq = '0;

        // trap sequence, no stalls
        enter = 1'b1;
        chk("tr_busy_t", S_BUSY, 0);
        settle();
        next_cycle();
        enter = 1'b0;
        chk("tr1_busy", S_BUSY, 1); chk("tr1_stall", S_STALL, 5'b00001);
        chk("tr1_flush", S_FLUSH, 5'b00010); chk("tr1_redir", S_REDIR, 0);
        chk("z1_busy", S_Z_BUSY, 1); chk("z1_redir", S_Z_REDIR, 0);
        settle();
        next_cycle();
        flushreq = 5'b00100;
        chk("tr2_stall", S_STALL, 5'b00001); chk("tr2_flush_ign", S_FLUSH, 5'b00010);
        chk("tr2_redir", S_REDIR, 0); chk("z2_redir", S_Z_REDIR, 1);
        settle();
        flushreq = '0;
        next_cycle();
        chk("tr3_redir", S_REDIR, 1); chk("tr3_flush", S_FLUSH, 5'b11110);
        chk("tr3_stall", S_STALL, 0); chk("tr3_busy", S_BUSY, 1);
        chk("z3_busy", S_Z_BUSY, 0); chk("z3_redir", S_Z_REDIR, 0);
        settle();
        next_cycle();
        chk("tr4_busy", S_BUSY, 0); chk("tr4_redir", S_REDIR, 0);
        chk("tr4_flush", S_FLUSH, 0);
        settle();

        // trap sequence with a stalled drain cycle and an ignored re-entry
        enter = 1'b1;
        next_cycle();
        enter = 1'b0;
        chk("sl1_busy", S_BUSY, 1);
        settle();
        next_cycle();
        stallreq = 5'b10000; enter = 1'b1;
        chk("sl2_stall", S_STALL, 5'b11111); chk("sl2_flush", S_FLUSH, 5'b00010);
        chk("sl2_redir", S_REDIR, 0);
        settle();
        next_cycle();
        stallreq = '0; enter = 1'b0;
        chk("sl3_redir", S_REDIR, 0); chk("sl3_busy", S_BUSY, 1);
        settle();
        next_cycle();
        chk("sl4_redir", S_REDIR, 1); chk("sl4_flush", S_FLUSH, 5'b11110);
        settle();
        next_cycle();
        chk("sl5_busy", S_BUSY, 0);
        settle();
        next_cycle();
        chk("sl6_busy_ign", S_BUSY, 0);
        settle();

        // enter held across the sequence restarts it
        enter = 1'b1;
        repeat (4) next_cycle();
        chk("hold_idle", S_BUSY, 0);
        settle();
        next_cycle();
        chk("hold_restart", S_BUSY, 1);
        settle();
        enter = 1'b0;
        repeat (3) next_cycle();
        chk("hold_done", S_BUSY, 0);
        settle();

        // watchdog
        next_cycle();
        chk("wd_start_cnt", S_CNT, 0); chk("wd_start_wdog", S_WDOG, 0);
        settle();
        stallreq = 5'b00001;
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            chk("wd_cnt", S_CNT, i); chk("wd_low", S_WDOG, 0);
            settle();
        end
        next_cycle();
        chk("wd_sat", S_CNT, 7); chk("wd_rise", S_WDOG, 1);
        settle();
        next_cycle();
        chk("wd_sat2", S_CNT, 7); chk("wd_hold", S_WDOG, 1);
        settle();
        stallreq = '0;
        next_cycle();
        chk("wd_rel_cnt", S_CNT, 0); chk("wd_rel_wdog", S_WDOG, 1);
        settle();
        next_cycle();
        chk("wd_fall", S_WDOG, 0);
        settle();

        // async reset while draining
        enter = 1'b1;
        next_cycle();
        enter = 1'b0;
        next_cycle();
        chk("ar_busy_pre", S_BUSY, 1); chk("ar_cnt_pre", S_CNT, 1);
        settle();
        rst_n = 1'b0;
        chk("ar_busy", S_BUSY, 0); chk("ar_cnt", S_CNT, 0); chk("ar_redir", S_REDIR, 0);
        settle();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("ar_no_redir", S_REDIR, 0); chk("ar_idle", S_BUSY, 0);
            settle();
        end
        rst_n = 1'b1;
        next_cycle();
        enter = 1'b1;
        next_cycle();
        enter = 1'b0;
        chk("ar_resume_busy", S_BUSY, 1);
        settle();
        next_cycle();
        chk("ar_resume_noredir", S_REDIR, 0);
        settle();
        next_cycle();
        chk("ar_resume_redir", S_REDIR, 1); chk("ar_resume_flush", S_FLUSH, 5'b11110);
        settle();
        next_cycle();
        chk("ar_resume_idle", S_BUSY, 0);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
